// File: rtl/touch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// touch_debounce_pkg
//   Shared definitions for the touch-panel pen-down conditioning block:
//   wake-suppression FSM state encoding, the electrical pen-down level of
//   PENIRQ, and default debounce timing (10 ms at 25 MHz).
// -----------------------------------------------------------------------------
package touch_debounce_pkg;

  // Wake-suppression FSM. The encodings are fixed so they read the same in
  // waveforms and in any software-visible debug taps.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,  // pen up (debounced)
    ST_PRESS_APP  = 2'd1,  // pen down, touch started with the backlight on
    ST_PRESS_WAKE = 2'd2   // pen down, touch started with the backlight off
  } touch_state_e;

  // PENIRQ is active-low: a 0 on the (synchronised) line means pen down.
  localparam logic PEN_DOWN = 1'b0;
  localparam logic PEN_UP   = 1'b1;

  // Default debounce window: 250000 cycles = 10 ms at 25 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int CNT_W_DEF           = 18;

endpackage : touch_debounce_pkg

// File: rtl/touch_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Two-flop synchroniser followed by a hold-time debouncer. A new level on
//   the synchronised input must persist for DEBOUNCE_CYCLES consecutive cycles
//   before the stable level follows it; any return to the stable level
//   restarts the count.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles a new level must hold (>= 1)
//   CNT_W            counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   i_Clk    in  system clock
//   i_Rst_n  in  synchronous active-low reset
//   i_Raw    in  asynchronous raw input (idles high)
//   o_Level  out registered stable level (raw polarity)
//   o_Rise   out strobe: stable level goes 0 -> 1 at the coming clock edge
//   o_Fall   out strobe: stable level goes 1 -> 0 at the coming clock edge
//
// o_Rise/o_Fall are decoded from the next-state logic so that a consumer can
// register its own reaction on the very edge where o_Level flips, with no
// extra pipeline stage between the filter and the consumer's outputs.
// -----------------------------------------------------------------------------
module debounce_filter
  import touch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  // Terminal count: the level flips on the edge where the counter would
  // otherwise step past this value, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             flip;

  // Synchroniser. Nothing past sync2_q ever looks at the raw input.
  // NOTE: reset is synchronous (sampled on the clock edge), so it lives inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1_q <= PEN_UP;
      sync2_q <= PEN_UP;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the values from
      // before the edge; blocking ones would collapse the chain into one flop.
      sync1_q <= i_Raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else leaves it unassigned (which would infer a latch).
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (sync2_q == level_q) begin
      // Input agrees with the accepted level: any partial count is discarded.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // New level has now been seen for DEBOUNCE_CYCLES consecutive cycles.
      level_d = ~level_q;
      cnt_d   = '0;
      flip    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt_q   <= '0;
      level_q <= PEN_UP;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_Level = level_q;
  assign o_Rise  = flip & ~level_q;
  assign o_Fall  = flip &  level_q;

endmodule : debounce_filter

// File: rtl/touch_debounce.sv
// -----------------------------------------------------------------------------
// touch_debounce
//   Conditions the raw PENIRQ pen-down interrupt from the touch-panel
//   controller. The synchronised, debounced pen level drives the backlight
//   timer's touch input; a gated copy plus press/release pulses go to the
//   application. A touch that begins while the backlight is off only wakes the
//   display: the application never sees it, for its whole duration.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles a new pen level must hold (>= 1)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   i_Clk       in  system clock, single domain
//   i_Rst_n     in  synchronous active-low reset
//   i_Pen_n     in  raw PENIRQ, asynchronous, 0 = pen down
//   i_Light     in  backlight state, 1 = on (registered upstream)
//   o_Touch     out debounced pen-down level, to the backlight timer
//   o_AppTouch  out debounced pen-down level, held 0 for a wake touch
//   o_Press     out one-cycle pulse, application press accepted
//   o_Release   out one-cycle pulse, application press ended
//
// All outputs are registered and update on the same edge as the debounced
// level, so o_Touch, o_AppTouch and o_Press/o_Release are edge-aligned.
// -----------------------------------------------------------------------------
module touch_debounce
  import touch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Pen_n,
  input  logic i_Light,
  output logic o_Touch,
  output logic o_AppTouch,
  output logic o_Press,
  output logic o_Release
);

  // ---------------------------------------------------------------------------
  // Synchronise + debounce
  // ---------------------------------------------------------------------------
  logic pen_level;     // debounced PENIRQ, raw polarity
  logic pen_up_evt;    // pen release accepted at the coming edge
  logic pen_down_evt;  // pen press accepted at the coming edge

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_filter (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Raw   (i_Pen_n),
    .o_Level (pen_level),
    .o_Rise  (pen_up_evt),
    .o_Fall  (pen_down_evt)
  );

  // ---------------------------------------------------------------------------
  // Wake-suppression FSM
  // ---------------------------------------------------------------------------
  touch_state_e state_q;
  touch_state_e state_d;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // i_Light is only looked at on the press edge. At that point the backlight
  // timer has not yet seen this touch (o_Touch reaches it a cycle later), so
  // the sampled value is the backlight state from before the touch. Once a
  // press is classified, backlight changes do not reclassify it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pen_down_evt) begin
          state_d = i_Light ? ST_PRESS_APP : ST_PRESS_WAKE;
        end
      end
      ST_PRESS_APP,
      ST_PRESS_WAKE: begin
        if (pen_up_evt) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (next values of the output registers)
  // ---------------------------------------------------------------------------
  logic touch_d;
  logic app_touch_d;
  logic press_d;
  logic release_d;

  always_comb begin
    // Touch level follows the filter's next level, independent of the FSM.
    if (pen_down_evt) begin
      touch_d = 1'b1;
    end else if (pen_up_evt) begin
      touch_d = 1'b0;
    end else begin
      touch_d = (pen_level == PEN_DOWN);
    end

    // Decoding the gated level from the next state lines it up with touch_d
    // on both the press and the release edge.
    app_touch_d = (state_d == ST_PRESS_APP);
    press_d     = (state_q == ST_IDLE) && pen_down_evt && i_Light;
    release_d   = (state_q == ST_PRESS_APP) && pen_up_evt;
  end

  // Output registers. Reset clears them without emitting a release, so a
  // press in flight at reset is abandoned silently.
  logic touch_q;
  logic app_touch_q;
  logic press_q;
  logic release_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      touch_q     <= 1'b0;
      app_touch_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      touch_q     <= touch_d;
      app_touch_q <= app_touch_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign o_Touch    = touch_q;
  assign o_AppTouch = app_touch_q;
  assign o_Press    = press_q;
  assign o_Release  = release_q;

endmodule : touch_debounce

// File: tb/tb_touch_debounce.sv
// -----------------------------------------------------------------------------
// tb_touch_debounce
//   Directed bench for touch_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Inputs change 1 time unit after a rising edge and outputs are sampled at
//   the same point, so "edge e" below is the rising edge that samples the
//   inputs set just before it, and the values checked after tick() are the
//   ones registered on that edge. A pen level sampled at edge k appears on
//   o_Touch after edge k+5.
// -----------------------------------------------------------------------------
module tb_touch_debounce;

  localparam int DC = 4;

  logic clk;
  logic rst_n;
  logic pen_n;
  logic light;
  logic touch;
  logic app_touch;
  logic press;
  logic release_p;

  int n_checks = 0;
  int n_errors = 0;

  touch_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (3)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Pen_n    (pen_n),
    .i_Light    (light),
    .o_Touch    (touch),
    .o_AppTouch (app_touch),
    .o_Press    (press),
    .o_Release  (release_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic t, input logic a,
                            input logic p, input logic r);
    check({tag, ".touch"},   32'(touch),     32'(t));
    check({tag, ".app"},     32'(app_touch), 32'(a));
    check({tag, ".press"},   32'(press),     32'(p));
    check({tag, ".release"}, 32'(release_p), 32'(r));
  endtask

  initial begin
    rst_n = 1'b0;
    pen_n = 1'b1;
    light = 1'b1;
    repeat (3) tick();
    check_outs("reset", 0, 0, 0, 0);

    // 1. Idle after reset, then an app press with the light on.
    rst_n = 1'b1;
    repeat (10) tick();
    check_outs("idle10", 0, 0, 0, 0);

    pen_n = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check_outs($sformatf("t1.e%0d", e), e >= 5, e >= 5, e == 5, 0);
    end

    // 4. Release of the app press.
    pen_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      check_outs($sformatf("t4.e%0d", e), e < 5, e < 5, 0, e == 5);
    end

    // 2. A 3-cycle low is rejected; a 4-cycle low two cycles later is
    //    accepted at edge 5+5=10 and released at edge 9+5=14.
    repeat (4) tick();
    for (int e = 0; e <= 16; e++) begin
      pen_n = ((e <= 2) || (e >= 5 && e <= 8)) ? 1'b0 : 1'b1;
      tick();
      check_outs($sformatf("t2.e%0d", e), e >= 10 && e < 14, e >= 10 && e < 14,
                 e == 10, e == 14);
    end

    // 3. Wake touch: light off at the press edge, turned on mid-press.
    repeat (4) tick();
    for (int e = 0; e <= 18; e++) begin
      pen_n = (e < 10) ? 1'b0 : 1'b1;
      light = (e >= 7) ? 1'b1 : 1'b0;
      tick();
      check_outs($sformatf("t3.e%0d", e), e >= 5 && e < 15, 0, 0, 0);
    end

    // 5. Reset sampled at edge 7 during an app press, pen kept down. Sync
    //    flops restart at pen up, so the press is re-seen at edge 8+5=13.
    repeat (4) tick();
    light = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      pen_n = 1'b0;
      rst_n = (e == 7) ? 1'b0 : 1'b1;
      tick();
      check_outs($sformatf("t5.e%0d", e), (e >= 5 && e < 7) || e >= 13,
                 (e >= 5 && e < 7) || e >= 13, e == 5 || e == 13, 0);
    end
    rst_n = 1'b1;
    pen_n = 1'b1;
    repeat (10) tick();
    check_outs("t5.after_release", 0, 0, 0, 1'b0);

    // 6. Chatter: toggling every 2 cycles never holds long enough.
    for (int e = 0; e < 40; e++) begin
      pen_n = ((e / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("t6.e%0d.touch", e),   32'(touch),     32'd0);
      check($sformatf("t6.e%0d.press", e),   32'(press),     32'd0);
      check($sformatf("t6.e%0d.release", e), 32'(release_p), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_touch_debounce
